// File: rtl/decode_stage_pkg.sv
// Shared instruction-word layout and FSM encoding for the decode stage.
// Assembler-side tests import this package to build words with the same field map.
package decode_stage_pkg;

    localparam int INSTR_W = 32;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 29;
    localparam int FORM_BIT  = 28;
    localparam int VEC_HI    = 27;
    localparam int VEC_LO    = 26;
    localparam int A_HI      = 25;
    localparam int A_LO      = 22;
    localparam int B_HI      = 21;
    localparam int B_LO      = 18;
    localparam int C_HI      = 17;
    localparam int C_LO      = 14;
    localparam int D_HI      = 13;
    localparam int D_LO      = 10;
    localparam int Y1_HI     = 9;
    localparam int Y1_LO     = 6;
    localparam int Y2_HI     = 5;
    localparam int Y2_LO     = 2;
    localparam int HCONST_BIT = 1;
    localparam int HALT_BIT  = 0;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_CONST = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic [2:0] op;
        logic       form;
        logic [1:0] vec;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] y1;
        logic [3:0] y2;
        logic       has_const;
        logic       halt;
    } instr_fields_t;

    function automatic instr_fields_t unpack_instr(input logic [INSTR_W-1:0] w);
        instr_fields_t f;
        f.op        = w[OP_HI:OP_LO];
        f.form      = w[FORM_BIT];
        f.vec       = w[VEC_HI:VEC_LO];
        f.a         = w[A_HI:A_LO];
        f.b         = w[B_HI:B_LO];
        f.c         = w[C_HI:C_LO];
        f.d         = w[D_HI:D_LO];
        f.y1        = w[Y1_HI:Y1_LO];
        f.y2        = w[Y2_HI:Y2_LO];
        f.has_const = w[HCONST_BIT];
        f.halt      = w[HALT_BIT];
        return f;
    endfunction

    function automatic logic [INSTR_W-1:0] pack_instr(input instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w                   = '0;
        w[OP_HI:OP_LO]      = f.op;
        w[FORM_BIT]         = f.form;
        w[VEC_HI:VEC_LO]    = f.vec;
        w[A_HI:A_LO]        = f.a;
        w[B_HI:B_LO]        = f.b;
        w[C_HI:C_LO]        = f.c;
        w[D_HI:D_LO]        = f.d;
        w[Y1_HI:Y1_LO]      = f.y1;
        w[Y2_HI:Y2_LO]      = f.y2;
        w[HCONST_BIT]       = f.has_const;
        w[HALT_BIT]         = f.halt;
        return w;
    endfunction

endpackage

// File: rtl/decode_stage.sv
// Instruction decode: accepts one- or two-word instructions, issues registered
// ALU/register-file controls one cycle after the final word, and parks in HALT on request.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        instr_ready,
    input  logic        resume,
    output logic [2:0]  op,
    output logic        form,
    output logic [1:0]  vec,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic [3:0]  Y1,
    output logic [3:0]  Y2,
    output logic [3:0]  zero_reg,
    output logic [1:0]  write,
    output logic        const_a,
    output logic [31:0] constant,
    output logic        halted
);

    logic [1:0]    r_state;
    instr_fields_t r_pend;
    logic [2:0]    r_op;
    logic          r_form;
    logic [1:0]    r_vec;
    logic [3:0]    r_rd_idx [4];
    logic [3:0]    r_y1;
    logic [3:0]    r_y2;
    logic [1:0]    r_write;
    logic          r_const_a;
    logic [31:0]   r_constant;

    instr_fields_t w_in;
    instr_fields_t w_iss_f;
    logic [1:0]    w_state_next;
    logic          w_issue;
    logic          w_pend_load;
    logic [31:0]   w_iss_const;

    assign w_in        = unpack_instr(instr_data);
    assign instr_ready = (r_state != ST_HALT);
    assign halted      = (r_state == ST_HALT);

    // Issue selects either the word just fetched or the parked first word plus its constant.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_pend_load  = 1'b0;
        w_iss_f      = w_in;
        w_iss_const  = '0;
        case (r_state)
            ST_FETCH: begin
                if (instr_valid) begin
                    if (w_in.has_const) begin
                        w_pend_load  = 1'b1;
                        w_state_next = ST_CONST;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = w_in.halt ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_CONST: begin
                w_iss_f = r_pend;
                if (instr_valid) begin
                    w_issue      = 1'b1;
                    w_iss_const  = instr_data;
                    w_state_next = r_pend.halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pend     <= '0;
            r_op       <= '0;
            r_form     <= 1'b0;
            r_vec      <= '0;
            r_rd_idx   <= '{default: 4'd0};
            r_y1       <= '0;
            r_y2       <= '0;
            r_write    <= '0;
            r_const_a  <= 1'b0;
            r_constant <= '0;
        end else begin
            r_state <= w_state_next;
            r_write <= 2'b00;
            if (w_pend_load) begin
                r_pend <= w_in;
            end
            if (w_issue) begin
                r_op        <= w_iss_f.op;
                r_form      <= w_iss_f.form;
                r_vec       <= w_iss_f.vec;
                r_rd_idx[0] <= w_iss_f.a;
                r_rd_idx[1] <= w_iss_f.b;
                r_rd_idx[2] <= w_iss_f.c;
                r_rd_idx[3] <= w_iss_f.d;
                r_y1        <= w_iss_f.y1;
                r_y2        <= w_iss_f.y2;
                r_write     <= {(w_iss_f.y2 != 4'd0), (w_iss_f.y1 != 4'd0)};
                r_const_a   <= w_iss_f.has_const;
                r_constant  <= w_iss_f.has_const ? w_iss_const : 32'd0;
            end
        end
    end

    // Register 0 is hardwired zero, so each read port flags it for the datapath.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign zero_reg[gi] = (r_rd_idx[gi] == 4'd0);
        end
    endgenerate

    assign op       = r_op;
    assign form     = r_form;
    assign vec      = r_vec;
    assign A        = r_rd_idx[0];
    assign B        = r_rd_idx[1];
    assign C        = r_rd_idx[2];
    assign D        = r_rd_idx[3];
    assign Y1       = r_y1;
    assign Y2       = r_y2;
    assign write    = r_write;
    assign const_a  = r_const_a;
    assign constant = r_constant;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors for issue timing,
// constants, halt/resume, reset abort and back-to-back streaming.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        resume;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  A, B, C, D, Y1, Y2;
    logic [3:0]  zero_reg;
    logic [1:0]  write;
    logic        const_a;
    logic [31:0] constant;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_ready(instr_ready),
        .resume     (resume),
        .op         (op),
        .form       (form),
        .vec        (vec),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .Y1         (Y1),
        .Y2         (Y2),
        .zero_reg   (zero_reg),
        .write      (write),
        .const_a    (const_a),
        .constant   (constant),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f_op, input logic f_form,
                                       input logic [1:0] f_vec, input logic [3:0] f_a,
                                       input logic [3:0] f_b, input logic [3:0] f_c,
                                       input logic [3:0] f_d, input logic [3:0] f_y1,
                                       input logic [3:0] f_y2, input logic f_hc,
                                       input logic f_halt);
        return {f_op, f_form, f_vec, f_a, f_b, f_c, f_d, f_y1, f_y2, f_hc, f_halt};
    endfunction

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 32'h0;
        resume      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_op",       {29'd0, op},       32'd0);
        chk("rst_zero_reg", {28'd0, zero_reg}, 32'hF);
        chk("rst_write",    {30'd0, write},    32'd0);
        chk("rst_ready",    {31'd0, instr_ready}, 32'd1);
        chk("rst_halted",   {31'd0, halted},   32'd0);
        chk("rst_constant", constant,          32'd0);

        // Single-word issue
        instr_valid = 1'b1;
        instr_data  = 32'h40480140;
        tick();
        instr_valid = 1'b0;
        instr_data  = 32'hFFFFFFFF;
        chk("w1_op",       {29'd0, op},       32'd2);
        chk("w1_A",        {28'd0, A},        32'd1);
        chk("w1_B",        {28'd0, B},        32'd2);
        chk("w1_Y1",       {28'd0, Y1},       32'd5);
        chk("w1_zero_reg", {28'd0, zero_reg}, 32'hC);
        chk("w1_write",    {30'd0, write},    32'd1);
        chk("w1_const_a",  {31'd0, const_a},  32'd0);
        tick();
        chk("w1_write_drop", {30'd0, write}, 32'd0);
        chk("w1_op_hold",    {29'd0, op},    32'd2);

        // Two-word instruction with a 3-cycle stall between words
        instr_valid = 1'b1;
        instr_data  = 32'h40480142;
        tick();
        chk("c_first_write", {30'd0, write},       32'd0);
        chk("c_ready",       {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b0;
        instr_data  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("c_stall%0d_write", i), {30'd0, write}, 32'd0);
        end
        instr_valid = 1'b1;
        instr_data  = 32'hDEADBEEF;
        tick();
        instr_valid = 1'b0;
        chk("c_const_a",  {31'd0, const_a}, 32'd1);
        chk("c_constant", constant,         32'hDEADBEEF);
        chk("c_write",    {30'd0, write},   32'd1);
        chk("c_op",       {29'd0, op},      32'd2);
        tick();
        chk("c_write_drop",    {30'd0, write}, 32'd0);
        chk("c_constant_hold", constant,       32'hDEADBEEF);

        // Halt then resume
        instr_valid = 1'b1;
        instr_data  = 32'h40480141;
        tick();
        chk("h_write",  {30'd0, write},       32'd1);
        chk("h_halted", {31'd0, halted},      32'd1);
        chk("h_ready",  {31'd0, instr_ready}, 32'd0);
        instr_data = 32'hE0000FC0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("h_idle%0d_write", i), {30'd0, write}, 32'd0);
        end
        chk("h_idle_op",     {29'd0, op},       32'd2);
        chk("h_idle_halted", {31'd0, halted},   32'd1);
        instr_valid = 1'b0;
        resume      = 1'b1;
        tick();
        resume = 1'b0;
        chk("h_resume_ready",  {31'd0, instr_ready}, 32'd1);
        chk("h_resume_halted", {31'd0, halted},      32'd0);
        chk("h_resume_write",  {30'd0, write},       32'd0);

        // Reset between the two words of a constant instruction
        instr_valid = 1'b1;
        instr_data  = 32'h40480142;
        tick();
        rst        = 1'b1;
        instr_data = 32'hDEADBEEF;
        tick();
        chk("r_in_rst_write", {30'd0, write}, 32'd0);
        rst         = 1'b0;
        instr_valid = 1'b0;
        tick();
        chk("r_write",    {30'd0, write},       32'd0);
        chk("r_op",       {29'd0, op},          32'd0);
        chk("r_A",        {28'd0, A},           32'd0);
        chk("r_zero_reg", {28'd0, zero_reg},    32'hF);
        chk("r_const_a",  {31'd0, const_a},     32'd0);
        chk("r_constant", constant,             32'd0);
        chk("r_ready",    {31'd0, instr_ready}, 32'd1);
        chk("r_halted",   {31'd0, halted},      32'd0);
        // A following single word must be decoded from FETCH, not as a constant
        instr_valid = 1'b1;
        instr_data  = mk(3'd3, 1'b0, 2'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        chk("r_post_op",      {29'd0, op},      32'd3);
        chk("r_post_const_a", {31'd0, const_a}, 32'd0);
        chk("r_post_write",   {30'd0, write},   32'd1);

        // Four back-to-back single words
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_data = mk(3'(k + 1), 1'b0, 2'd0, 4'(k + 1), 4'd0, 4'd0, 4'd0,
                            4'(k + 2), 4'd0, 1'b0, 1'b0);
            tick();
            chk($sformatf("s%0d_write", k),    {30'd0, write},    32'd1);
            chk($sformatf("s%0d_op", k),       {29'd0, op},       32'(k + 1));
            chk($sformatf("s%0d_Y1", k),       {28'd0, Y1},       32'(k + 2));
            chk($sformatf("s%0d_zero_reg", k), {28'd0, zero_reg}, 32'hE);
        end
        instr_valid = 1'b0;
        tick();
        chk("s_end_write", {30'd0, write}, 32'd0);

        // Remaining fields and Y2-only write
        instr_valid = 1'b1;
        instr_data  = mk(3'd7, 1'b1, 2'd3, 4'd0, 4'd15, 4'd9, 4'd0, 4'd0, 4'd12, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        chk("f_op",       {29'd0, op},       32'd7);
        chk("f_form",     {31'd0, form},     32'd1);
        chk("f_vec",      {30'd0, vec},      32'd3);
        chk("f_B",        {28'd0, B},        32'd15);
        chk("f_C",        {28'd0, C},        32'd9);
        chk("f_Y2",       {28'd0, Y2},       32'd12);
        chk("f_zero_reg", {28'd0, zero_reg}, 32'h9);
        chk("f_write",    {30'd0, write},    32'd2);

        // No write targets, then stray resume in FETCH
        instr_valid = 1'b1;
        instr_data  = mk(3'd5, 1'b0, 2'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        chk("z_op",       {29'd0, op},       32'd5);
        chk("z_write",    {30'd0, write},    32'd0);
        chk("z_zero_reg", {28'd0, zero_reg}, 32'h0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("z_resume_ready",  {31'd0, instr_ready}, 32'd1);
        chk("z_resume_halted", {31'd0, halted},      32'd0);
        chk("z_resume_write",  {30'd0, write},       32'd0);
        instr_valid = 1'b1;
        instr_data  = mk(3'd1, 1'b0, 2'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        chk("z_after_op",    {29'd0, op},    32'd1);
        chk("z_after_write", {30'd0, write}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
